sysid_checker: RTL



---
 rtl/sysid_checker_pkg.sv | 21 ++
 rtl/sysid_read_engine.sv | 65 ++++++
 rtl/sysid_checker.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sysid_checker_pkg.sv
// Purpose: shared types and constants for the sysid boot checker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        AUTO,
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        CHECK
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int TMO_W = 16;

endpackage

// File: rtl/sysid_read_engine.sv
// Purpose: one Avalon-MM word read (request and wait phases driven by the caller) with timeout and retry counting.
// Latency: combinational strobes; ok asserts in the wait phase on the cycle readdatavalid arrives.
// Backpressure: read/address held while avm_waitrequest=1; timeout counts cycles in both phases.
module sysid_read_engine
    import sysid_checker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        req,
    input  logic        addr,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] rdata,
    output logic        accept,
    output logic        ok,
    output logic        retry,
    output logic        fail
);

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIM = 8'(RETRY_MAX);

    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       retry_cnt;
    logic             tmo_hit;

    // Bus strobes and outcome decode; a response in the request phase is stale and ignored,
    // and a response landing on the timeout cycle beats the timeout.
    always_comb begin
        avm_address = addr;
        avm_read    = go & req & ~reset;
        rdata       = avm_readdata;
        accept      = avm_read & ~avm_waitrequest;
        ok          = go & ~req & avm_readdatavalid;
        tmo_hit     = go & (tmo_cnt == TMO_LAST) & ~ok;
        fail        = tmo_hit & (retry_cnt >= RETRY_LIM);
        retry       = tmo_hit & ~fail;
    end

    // Per-attempt cycle counter: restarts whenever a request phase is (re)entered.
    always_ff @(posedge clock) begin
        if (reset || !go || ok || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Retry counter: one bump per expired attempt, cleared between words.
    always_ff @(posedge clock) begin
        if (reset || !go || ok) begin
            retry_cnt <= '0;
        end else if (tmo_hit) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// Purpose: reads sysid ID (word 0) and timestamp (word 1) after reset or on start, compares with build-time values.
// Latency: done pulses 6 cycles after the cycle the FSM leaves IDLE/AUTO with a zero-wait slave; +1 per waitrequest cycle.
// Backpressure: holds address/read under avm_waitrequest; per-read timeout with bounded retries. Option: SYSID_CHECK_PERIODIC_EN.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1575193418,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          RETRY_MAX      = 3
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    parameter int          PERIOD_CYCLES  = 50_000_000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t      state;
    state_t      state_nxt;
    logic        go;
    logic        req;
    logic        addr;
    logic        launch;
    logic        period_hit;
    logic [31:0] eng_rdata;
    logic        eng_accept;
    logic        eng_ok;
    logic        eng_retry;
    logic        eng_fail;

`ifdef SYSID_CHECK_PERIODIC_EN
    logic [31:0] period_cnt;

    // Idle-time interval counter; restarts on every launch and whenever a check is running.
    always_ff @(posedge clock) begin
        if (reset || state != IDLE || launch) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign period_hit = (state == IDLE) && (period_cnt == 32'(PERIOD_CYCLES - 1));
`else
    assign period_hit = 1'b0;
`endif

    assign launch = (state == IDLE) && (start || period_hit);

    sysid_read_engine #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .RETRY_MAX      (RETRY_MAX)
    ) u_engine (
        .clock             (clock),
        .reset             (reset),
        .go                (go),
        .req               (req),
        .addr              (addr),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .rdata             (eng_rdata),
        .accept            (eng_accept),
        .ok                (eng_ok),
        .retry             (eng_retry),
        .fail              (eng_fail)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= AUTO;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencing: ID word then timestamp word through the engine, then compare.
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        req       = 1'b0;
        addr      = SYSID_ADDR_ID;
        busy      = 1'b0;
        case (state)
            AUTO: state_nxt = ID_REQ;
            IDLE: if (launch) state_nxt = ID_REQ;
            ID_REQ: begin
                go   = 1'b1;
                req  = 1'b1;
                busy = 1'b1;
                if (eng_fail)        state_nxt = IDLE;
                else if (eng_retry)  state_nxt = ID_REQ;
                else if (eng_accept) state_nxt = ID_WAIT;
            end
            ID_WAIT: begin
                go   = 1'b1;
                busy = 1'b1;
                if (eng_ok)         state_nxt = TS_REQ;
                else if (eng_fail)  state_nxt = IDLE;
                else if (eng_retry) state_nxt = ID_REQ;
            end
            TS_REQ: begin
                go   = 1'b1;
                req  = 1'b1;
                addr = SYSID_ADDR_TS;
                busy = 1'b1;
                if (eng_fail)        state_nxt = IDLE;
                else if (eng_retry)  state_nxt = TS_REQ;
                else if (eng_accept) state_nxt = TS_WAIT;
            end
            TS_WAIT: begin
                go   = 1'b1;
                addr = SYSID_ADDR_TS;
                busy = 1'b1;
                if (eng_ok)         state_nxt = CHECK;
                else if (eng_fail)  state_nxt = IDLE;
                else if (eng_retry) state_nxt = TS_REQ;
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = AUTO;
        endcase
    end

    // Captured words and status; done and the verdict appear together the cycle after CHECK or a final timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                timeout <= 1'b0;
            end
            if (state == IDLE && start) begin
                id_ok <= 1'b0;
                ts_ok <= 1'b0;
            end
            if (state == ID_WAIT && eng_ok) begin
                id_value <= eng_rdata;
            end
            if (state == TS_WAIT && eng_ok) begin
                ts_value <= eng_rdata;
            end
            if (state == CHECK) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TS);
                done  <= 1'b1;
            end
            if (eng_fail) begin
                timeout <= 1'b1;
                done    <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
            end
        end
    end

endmodule
